// File: rtl/gpio_rgb_arbiter_if.sv
// Handshake and output bus of the RGB output sequencer.
// The producer side uses the master modport; the sequencer uses the slave modport.
interface gpio_rgb_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int GROUPS = 40000
);
    localparam int CW = $clog2(GROUPS + 1);

    logic [WIDTH-1:0] inR;
    logic [WIDTH-1:0] inG;
    logic [WIDTH-1:0] inB;
    logic             validR;
    logic             validG;
    logic             validB;
    logic             readyR;
    logic             readyG;
    logic             readyB;
    logic [WIDTH-1:0] GPIO;
    logic             GPIOEnR;
    logic             GPIOEnG;
    logic             GPIOEnB;
    logic             GPIOEn;
    logic [CW-1:0]    groupCount;
    logic             done;

    modport master (
        output inR, inG, inB, validR, validG, validB,
        input  readyR, readyG, readyB,
        input  GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, groupCount, done
    );

    modport slave (
        input  inR, inG, inB, validR, validG, validB,
        output readyR, readyG, readyB,
        output GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, groupCount, done
    );
endinterface

// File: rtl/gpio_rgb_arbiter.sv
// Buffers R/G/B lane words in small FIFOs and serialises them onto one GPIO bus.
// GPIO_STRICT_ORDER_EN defined: strict R->G->B rotation; undefined: work-conserving round-robin.
module gpio_rgb_arbiter #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int GROUPS = 40000
) (
    input  logic                clk,
    input  logic                rst,
    gpio_rgb_arbiter_if.slave   bus
);
    localparam int CW = $clog2(GROUPS + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SEND_R = 2'd0,
        SEND_G = 2'd1,
        SEND_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    logic [WIDTH-1:0] in_s    [3];
    logic [WIDTH-1:0] head_s  [3];
    logic [2:0]       valid_s;
    logic [2:0]       ready_s;
    logic [2:0]       push_s;
    logic [2:0]       pop_s;

    logic [WIDTH-1:0] mem_q    [3][DEPTH];
    logic [WIDTH-1:0] mem_d    [3][DEPTH];
    logic [PW-1:0]    wr_ptr_q [3];
    logic [PW-1:0]    wr_ptr_d [3];
    logic [PW-1:0]    rd_ptr_q [3];
    logic [PW-1:0]    rd_ptr_d [3];
    logic [OW-1:0]    occ_q    [3];
    logic [OW-1:0]    occ_d    [3];

    state_t           state_q, state_d;
    logic             grant_vld_s;
    logic [1:0]       grant_lane_s;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] gpio_q, gpio_d;
    logic [2:0]       stb_q, stb_d;
    logic             gpio_en_q, gpio_en_d;

    function automatic logic [1:0] next_lane(input logic [1:0] lane);
        case (lane)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    assign in_s[0] = bus.inR;
    assign in_s[1] = bus.inG;
    assign in_s[2] = bus.inB;
    assign valid_s = {bus.validB, bus.validG, bus.validR};

    // Lane handshake: ready depends on registered occupancy and done only.
    always_comb begin
        ready_s = 3'b000;
        push_s  = 3'b000;
        pop_s   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ready_s[i] = (occ_q[i] != OW'(DEPTH)) && !done_q;
            push_s[i]  = valid_s[i] && ready_s[i];
            pop_s[i]   = grant_vld_s && (grant_lane_s == 2'(i));
            head_s[i]  = mem_q[i][rd_ptr_q[i]];
        end
    end

    // Grant selection; the state doubles as the lane searched first.
    always_comb begin
        logic [1:0] cand_v;
        grant_vld_s  = 1'b0;
        grant_lane_s = 2'd0;
        cand_v       = state_q;
        if (state_q != DONE) begin
`ifdef GPIO_STRICT_ORDER_EN
            if (occ_q[cand_v] != {OW{1'b0}}) begin
                grant_vld_s  = 1'b1;
                grant_lane_s = cand_v;
            end else begin
                grant_vld_s  = 1'b0;
            end
`else
            for (int k = 0; k < 3; k++) begin
                if (!grant_vld_s && (occ_q[cand_v] != {OW{1'b0}})) begin
                    grant_vld_s  = 1'b1;
                    grant_lane_s = cand_v;
                end else begin
                    grant_vld_s  = grant_vld_s;
                end
                cand_v = next_lane(cand_v);
            end
`endif
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    // Next state, B-word group counter and frame-done detection.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        case (state_q)
            SEND_R, SEND_G, SEND_B: begin
                if (grant_vld_s) begin
                    if (grant_lane_s == 2'd2) begin
                        count_d = count_q + CW'(1);
                        if (count_d == CW'(GROUPS)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SEND_R;
                        end
                    end else begin
                        state_d = state_t'(next_lane(grant_lane_s));
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = SEND_R;
        endcase
    end

    // Output word, one-hot strobe and sticky enable.
    always_comb begin
        gpio_d    = gpio_q;
        stb_d     = 3'b000;
        gpio_en_d = gpio_en_q;
        if (grant_vld_s) begin
            gpio_d              = head_s[grant_lane_s];
            stb_d[grant_lane_s] = 1'b1;
            gpio_en_d           = 1'b1;
        end else begin
            gpio_d = gpio_q;
        end
    end

    // FIFO pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        for (int i = 0; i < 3; i++) begin
            if (push_s[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_s[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i];
            end
            if (pop_s[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            end else begin
                rd_ptr_d[i] = rd_ptr_q[i];
            end
            case ({push_s[i], pop_s[i]})
                2'b10:   occ_d[i] = occ_q[i] + OW'(1);
                2'b01:   occ_d[i] = occ_q[i] - OW'(1);
                default: occ_d[i] = occ_q[i];
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEND_R;
            count_q   <= {CW{1'b0}};
            done_q    <= 1'b0;
            gpio_q    <= {WIDTH{1'b0}};
            stb_q     <= 3'b000;
            gpio_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            done_q    <= done_d;
            gpio_q    <= gpio_d;
            stb_q     <= stb_d;
            gpio_en_q <= gpio_en_d;
        end
    end

    // Lane FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= {PW{1'b0}};
                rd_ptr_q[i] <= {PW{1'b0}};
                occ_q[i]    <= {OW{1'b0}};
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= {WIDTH{1'b0}};
                end
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign bus.readyR     = ready_s[0];
    assign bus.readyG     = ready_s[1];
    assign bus.readyB     = ready_s[2];
    assign bus.GPIO       = gpio_q;
    assign bus.GPIOEnR    = stb_q[0];
    assign bus.GPIOEnG    = stb_q[1];
    assign bus.GPIOEnB    = stb_q[2];
    assign bus.GPIOEn     = gpio_en_q;
    assign bus.groupCount = count_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_gpio_rgb_arbiter.sv
// Directed bench for gpio_rgb_arbiter (DEPTH=2, GROUPS=3); outputs sampled at negedge.
module tb_gpio_rgb_arbiter;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 2;
    localparam int GROUPS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gpio_rgb_arbiter_if #(.WIDTH(WIDTH), .GROUPS(GROUPS)) bus ();

    gpio_rgb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GROUPS(GROUPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] base [3] = '{32'h11223300, 32'h55667700, 32'h99AABB00};
    int          idx  [3];
    bit          fire [3];
    bit          vld  [3];

    wire [2:0] stb_w = {bus.GPIOEnB, bus.GPIOEnG, bus.GPIOEnR};
    wire [2:0] rdy_w = {bus.readyB, bus.readyG, bus.readyR};

    // Advance each lane's word index after an accepted push, then drive the next word.
    task automatic update_lanes();
        for (int l = 0; l < 3; l++) begin
            if (fire[l]) idx[l]++;
            fire[l] = vld[l] && rdy_w[l];
        end
        bus.inR    = base[0] + 32'(idx[0]);
        bus.inG    = base[1] + 32'(idx[1]);
        bus.inB    = base[2] + 32'(idx[2]);
        bus.validR = vld[0];
        bus.validG = vld[1];
        bus.validB = vld[2];
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int l = 0; l < 3; l++) begin
            vld[l] = 1'b0; fire[l] = 1'b0; idx[l] = 0;
        end
        bus.inR = 32'h0; bus.inG = 32'h0; bus.inB = 32'h0;
        bus.validR = 1'b0; bus.validG = 1'b0; bus.validB = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.GPIO !== 32'h0) begin n_bad++; $display("FAIL reset_gpio: got %h expected %h", bus.GPIO, 32'h0); end
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL reset_stb: got %b expected %b", stb_w, 3'b000); end
        n_cmp++; if (bus.GPIOEn !== 1'b0) begin n_bad++; $display("FAIL reset_gpioen: got %b expected 0", bus.GPIOEn); end
        n_cmp++; if (bus.groupCount !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.groupCount); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_cmp++; if (rdy_w !== 3'b111) begin n_bad++; $display("FAIL reset_ready: got %b expected %b", rdy_w, 3'b111); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int l = 0; l < 3; l++) vld[l] = 1'b1;
        update_lanes();
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL mid_first_stb: got %b expected %b", stb_w, 3'b000); end
        for (int l = 0; l < 3; l++) vld[l] = 1'b0;
        update_lanes();
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b001) begin n_bad++; $display("FAIL mid_r_stb: got %b expected %b", stb_w, 3'b001); end
        n_cmp++; if (bus.GPIO !== base[0]) begin n_bad++; $display("FAIL mid_r_word: got %h expected %h", bus.GPIO, base[0]); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.GPIO !== 32'h0) begin n_bad++; $display("FAIL mid_rst_gpio: got %h expected %h", bus.GPIO, 32'h0); end
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL mid_rst_stb: got %b expected %b", stb_w, 3'b000); end
        n_cmp++; if (bus.GPIOEn !== 1'b0) begin n_bad++; $display("FAIL mid_rst_gpioen: got %b expected 0", bus.GPIOEn); end
        n_cmp++; if (bus.groupCount !== 2'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d expected 0", bus.groupCount); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL mid_stale_stb: cycle %0d got %b expected %b", c, stb_w, 3'b000); end
            n_cmp++; if (rdy_w !== 3'b111) begin n_bad++; $display("FAIL mid_ready: cycle %0d got %b expected %b", c, rdy_w, 3'b111); end
        end
    endtask

    task automatic test_full_throughput_and_done();
        logic [2:0]  exp_stb;
        logic [31:0] exp_word;
        int          lane;
        apply_reset();
        for (int l = 0; l < 3; l++) vld[l] = 1'b1;
        update_lanes();
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL full_first_stb: got %b expected %b", stb_w, 3'b000); end
        n_cmp++; if (bus.GPIOEn !== 1'b0) begin n_bad++; $display("FAIL full_first_gpioen: got %b expected 0", bus.GPIOEn); end
        update_lanes();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            lane     = k % 3;
            exp_stb  = 3'(1 << lane);
            exp_word = base[lane] + 32'(k / 3);
            n_cmp++; if (stb_w !== exp_stb) begin n_bad++; $display("FAIL full_stb: word %0d got %b expected %b", k, stb_w, exp_stb); end
            n_cmp++; if (bus.GPIO !== exp_word) begin n_bad++; $display("FAIL full_word: word %0d got %h expected %h", k, bus.GPIO, exp_word); end
            n_cmp++; if (bus.GPIOEn !== 1'b1) begin n_bad++; $display("FAIL full_gpioen: word %0d got %b expected 1", k, bus.GPIOEn); end
            n_cmp++; if (bus.groupCount !== 2'((k + 1) / 3)) begin n_bad++; $display("FAIL full_count: word %0d got %0d expected %0d", k, bus.groupCount, (k + 1) / 3); end
            n_cmp++; if (bus.done !== (k == 8)) begin n_bad++; $display("FAIL full_done: word %0d got %b expected %b", k, bus.done, (k == 8)); end
            update_lanes();
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL absorb_stb: cycle %0d got %b expected %b", c, stb_w, 3'b000); end
            n_cmp++; if (rdy_w !== 3'b000) begin n_bad++; $display("FAIL absorb_ready: cycle %0d got %b expected %b", c, rdy_w, 3'b000); end
            n_cmp++; if (bus.groupCount !== 2'd3) begin n_bad++; $display("FAIL absorb_count: cycle %0d got %0d expected 3", c, bus.groupCount); end
            n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL absorb_done: cycle %0d got %b expected 1", c, bus.done); end
            n_cmp++; if (bus.GPIO !== base[2] + 32'd2) begin n_bad++; $display("FAIL absorb_gpio: cycle %0d got %h expected %h", c, bus.GPIO, base[2] + 32'd2); end
            update_lanes();
        end
    endtask

`ifdef GPIO_STRICT_ORDER_EN
    task automatic test_backpressure();
        apply_reset();
        vld[0] = 1'b1; vld[1] = 1'b1;
        update_lanes();
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL bp_first_stb: got %b expected %b", stb_w, 3'b000); end
        update_lanes();
        @(negedge clk);
        n_cmp++; if ({stb_w, bus.GPIO} !== {3'b001, base[0]}) begin n_bad++; $display("FAIL bp_r0: got %b/%h expected %b/%h", stb_w, bus.GPIO, 3'b001, base[0]); end
        update_lanes();
        @(negedge clk);
        n_cmp++; if ({stb_w, bus.GPIO} !== {3'b010, base[1]}) begin n_bad++; $display("FAIL bp_g0: got %b/%h expected %b/%h", stb_w, bus.GPIO, 3'b010, base[1]); end
        update_lanes();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL bp_stall_stb: cycle %0d got %b expected %b", c, stb_w, 3'b000); end
            n_cmp++; if (rdy_w[1:0] !== 2'b00) begin n_bad++; $display("FAIL bp_stall_ready: cycle %0d got %b expected %b", c, rdy_w[1:0], 2'b00); end
            n_cmp++; if (bus.GPIO !== base[1]) begin n_bad++; $display("FAIL bp_stall_gpio: cycle %0d got %h expected %h", c, bus.GPIO, base[1]); end
            if (c == 3) vld[2] = 1'b1;
            update_lanes();
        end
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL bp_bpush_stb: got %b expected %b", stb_w, 3'b000); end
        vld[2] = 1'b0;
        update_lanes();
        @(negedge clk);
        n_cmp++; if ({stb_w, bus.GPIO} !== {3'b100, base[2]}) begin n_bad++; $display("FAIL bp_b0: got %b/%h expected %b/%h", stb_w, bus.GPIO, 3'b100, base[2]); end
        n_cmp++; if (bus.groupCount !== 2'd1) begin n_bad++; $display("FAIL bp_count: got %0d expected 1", bus.groupCount); end
        update_lanes();
        @(negedge clk);
        n_cmp++; if ({stb_w, bus.GPIO} !== {3'b001, base[0] + 32'd1}) begin n_bad++; $display("FAIL bp_r1: got %b/%h expected %b/%h", stb_w, bus.GPIO, 3'b001, base[0] + 32'd1); end
        update_lanes();
        @(negedge clk);
        n_cmp++; if ({stb_w, bus.GPIO} !== {3'b010, base[1] + 32'd1}) begin n_bad++; $display("FAIL bp_g1: got %b/%h expected %b/%h", stb_w, bus.GPIO, 3'b010, base[1] + 32'd1); end
        update_lanes();
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL bp_restall_stb: got %b expected %b", stb_w, 3'b000); end
    endtask
`else
    task automatic test_skip_empty();
        logic [31:0] exp_word;
        int          lane;
        apply_reset();
        vld[0] = 1'b1; vld[1] = 1'b1;
        update_lanes();
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL skip_first_stb: got %b expected %b", stb_w, 3'b000); end
        update_lanes();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            lane     = k % 2;
            exp_word = base[lane] + 32'(k / 2);
            n_cmp++; if (stb_w !== 3'(1 << lane)) begin n_bad++; $display("FAIL skip_stb: word %0d got %b expected %b", k, stb_w, 3'(1 << lane)); end
            n_cmp++; if (bus.GPIO !== exp_word) begin n_bad++; $display("FAIL skip_word: word %0d got %h expected %h", k, bus.GPIO, exp_word); end
            n_cmp++; if (bus.groupCount !== 2'd0) begin n_bad++; $display("FAIL skip_count: word %0d got %0d expected 0", k, bus.groupCount); end
            n_cmp++; if (bus.readyB !== 1'b1) begin n_bad++; $display("FAIL skip_readyb: word %0d got %b expected 1", k, bus.readyB); end
            update_lanes();
        end
    endtask

    task automatic test_single_lane_g();
        apply_reset();
        bus.inG    = 32'h0000_0001;
        bus.validG = 1'b1;
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL g_first_stb: got %b expected %b", stb_w, 3'b000); end
        bus.inG = 32'h0000_0002;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++; if (stb_w !== 3'b010) begin n_bad++; $display("FAIL g_stb: word %0d got %b expected %b", k, stb_w, 3'b010); end
            n_cmp++; if (bus.GPIO !== 32'(k)) begin n_bad++; $display("FAIL g_word: word %0d got %h expected %h", k, bus.GPIO, 32'(k)); end
            n_cmp++; if (bus.readyG !== 1'b1) begin n_bad++; $display("FAIL g_ready: word %0d got %b expected 1", k, bus.readyG); end
            if (k < 3) bus.inG = 32'(k + 2);
            else       bus.validG = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (stb_w !== 3'b000) begin n_bad++; $display("FAIL g_tail_stb: got %b expected %b", stb_w, 3'b000); end
        n_cmp++; if (bus.groupCount !== 2'd0) begin n_bad++; $display("FAIL g_count: got %0d expected 0", bus.groupCount); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midstream();
        test_full_throughput_and_done();
`ifdef GPIO_STRICT_ORDER_EN
        test_backpressure();
`else
        test_skip_empty();
        test_single_lane_g();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
